// File: rtl/zbt_pkg.sv
// zbt_pkg: shared op codes, byte-enable constant and command FSM states for the ZBT ring buffer
package zbt_pkg;
  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [3:0] BWE_ALL  = 4'hF;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;
endpackage

// File: rtl/zbt_rr_arbiter.sv
// zbt_rr_arbiter: two-way round-robin grant (write vs read); flag starts write-first and flips on each contested grant
module zbt_rr_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req_w,
  input  logic i_req_r,
  output logic o_gnt_w,
  output logic o_gnt_r
);
  logic r_rd_first;
  always_comb begin
    o_gnt_w = i_en && i_req_w && !(i_req_r && r_rd_first);
    o_gnt_r = i_en && i_req_r && !(i_req_w && !r_rd_first);
  end
  always_ff @(posedge clk) begin
    if (rst) r_rd_first <= 1'b0;
    else if (i_en && i_req_w && i_req_r) r_rd_first <= !r_rd_first;
  end
endmodule

// File: rtl/zbt_ring_buffer.sv
// zbt_ring_buffer: circular SRAM region fed by write/read ports, issuing ZBT ops; ZBT_RB_OVERWRITE_EN lets writes evict the oldest word when full
module zbt_ring_buffer
  import zbt_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 36,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int DEPTH_LOG2 = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_27mhz,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_ready,
  input  logic                  rd_req,
  output logic                  rd_ack,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic [1:0]            zbt_op,
  output logic [ADDR_W-1:0]     zbt_addr,
  output logic [DATA_W-1:0]     zbt_din,
  output logic [3:0]            zbt_bwe,
  input  logic                  zbt_ready,
  input  logic [DATA_W-1:0]     zbt_dout,
  input  logic                  zbt_nd
);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  state_t                r_state, w_next;
  logic [DEPTH_LOG2-1:0] r_head, r_tail;
  logic [DEPTH_LOG2:0]   r_count;
  logic [OUT_W-1:0]      r_out;
  logic [1:0]            r_op;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_din, r_rd_data;
  logic [3:0]            r_bwe;
  logic                  r_rd_valid;
  logic                  w_sel, w_wr_el, w_rd_el, w_gnt_w, w_gnt_r, w_nd_ok;
`ifdef ZBT_RB_OVERWRITE_EN
  assign w_wr_el = wr_valid;
`else
  assign w_wr_el = wr_valid && !full;
`endif
  assign w_rd_el = rd_req && !empty && (r_out < OUT_W'(MAX_OUTSTANDING));
  assign w_sel   = (r_state == S_IDLE) && zbt_ready && !reset;
  assign w_nd_ok = zbt_nd && (r_out != '0);
  zbt_rr_arbiter u_arb (
    .clk     (clk_27mhz),
    .rst     (reset),
    .i_en    (w_sel),
    .i_req_w (w_wr_el),
    .i_req_r (w_rd_el),
    .o_gnt_w (w_gnt_w),
    .o_gnt_r (w_gnt_r)
  );
  always_comb begin
    w_next   = (r_state == S_ISSUE) ? S_GAP :
               (r_state == S_GAP) ? S_IDLE :
               (w_gnt_w || w_gnt_r) ? S_ISSUE : S_IDLE;
    wr_ready = w_gnt_w;
    rd_ack   = w_gnt_r;
    zbt_op   = (r_state == S_ISSUE) ? r_op : OP_IDLE;
    zbt_bwe  = (r_state == S_ISSUE) ? r_bwe : 4'h0;
    zbt_addr = r_addr;
    zbt_din  = r_din;
    rd_data  = r_rd_data;
    rd_valid = r_rd_valid;
    count    = r_count;
    full     = (r_count == FULL_CNT);
    empty    = (r_count == '0);
  end
  always_ff @(posedge clk_27mhz) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_out      <= '0;
      r_op       <= OP_IDLE;
      r_addr     <= BASE_ADDR;
      r_din      <= '0;
      r_bwe      <= 4'h0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_gnt_w) begin
        r_op    <= OP_WRITE;
        r_addr  <= BASE_ADDR + ADDR_W'(r_tail);
        r_din   <= wr_data;
        r_bwe   <= BWE_ALL;
        r_tail  <= r_tail + 1'b1;
        // a write while full only happens when overwriting: drop the oldest word
        r_head  <= full ? r_head + 1'b1 : r_head;
        r_count <= full ? r_count : r_count + 1'b1;
      end else if (w_gnt_r) begin
        r_op    <= OP_READ;
        r_addr  <= BASE_ADDR + ADDR_W'(r_head);
        r_bwe   <= 4'h0;
        r_head  <= r_head + 1'b1;
        r_count <= r_count - 1'b1;
      end
      r_out      <= r_out + OUT_W'(w_gnt_r) - OUT_W'(w_nd_ok);
      r_rd_valid <= w_nd_ok;
      if (w_nd_ok) r_rd_data <= zbt_dout;
    end
  end
endmodule

// File: tb/tb_zbt_ring_buffer.sv
// tb_zbt_ring_buffer: scoreboard bench for zbt_ring_buffer with a small ZBT responder; honours ZBT_RB_OVERWRITE_EN
module tb_zbt_ring_buffer;
  import zbt_pkg::*;
  localparam int AW = 19;
  localparam int DW = 36;
  localparam int DL = 3;
  localparam int DEPTH = 8;
  localparam logic [AW-1:0] BASE = 19'h00010;
  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } op_t;
  logic          clk_27mhz = 1'b0;
  logic          reset, wr_valid, wr_ready, rd_req, rd_ack, rd_valid, full, empty;
  logic          zbt_ready, zbt_nd;
  logic [DW-1:0] wr_data, rd_data, zbt_din, zbt_dout;
  logic [DL:0]   count;
  logic [1:0]    zbt_op;
  logic [AW-1:0] zbt_addr;
  logic [3:0]    zbt_bwe;
  op_t           exp_op[$];
  op_t           mon_e;
  logic [DW-1:0] exp_rd[$], ring[$], pend[$];
  logic [DW-1:0] mem[int];
  logic [1:0]    prev_op = OP_IDLE;
  int tl = 0, hd = 0, n_cmp = 0, n_bad = 0, n_rdv = 0, nd_credit = 1000000;
  always #18 clk_27mhz = ~clk_27mhz;
  zbt_ring_buffer #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE), .DEPTH_LOG2(DL), .MAX_OUTSTANDING(4)) dut (
    .clk_27mhz(clk_27mhz), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .full(full), .empty(empty), .zbt_op(zbt_op), .zbt_addr(zbt_addr), .zbt_din(zbt_din),
    .zbt_bwe(zbt_bwe), .zbt_ready(zbt_ready), .zbt_dout(zbt_dout), .zbt_nd(zbt_nd)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void exp_write(input logic [DW-1:0] d);
    op_t e;
    e.op = OP_WRITE; e.addr = BASE + AW'(tl); e.din = d;
    exp_op.push_back(e);
    tl = (tl + 1) % DEPTH;
    if (ring.size() == DEPTH) begin
      ring.delete(0);
      hd = (hd + 1) % DEPTH;
    end
    ring.push_back(d);
  endfunction
  function automatic void exp_read();
    op_t e;
    e.op = OP_READ; e.addr = BASE + AW'(hd); e.din = '0;
    exp_op.push_back(e);
    hd = (hd + 1) % DEPTH;
    if (ring.size() > 0) exp_rd.push_back(ring.pop_front());
  endfunction
  // ZBT responder: captures writes, queues reads and returns them with nd while credit allows
  always @(negedge clk_27mhz) begin
    zbt_nd = 1'b0;
    if (nd_credit > 0 && pend.size() > 0) begin
      zbt_nd = 1'b1;
      zbt_dout = pend.pop_front();
      nd_credit--;
    end
    if (zbt_op == OP_WRITE) mem[int'(zbt_addr)] = zbt_din;
    else if (zbt_op == OP_READ) pend.push_back(mem.exists(int'(zbt_addr)) ? mem[int'(zbt_addr)] : '0);
  end
  always @(negedge clk_27mhz) begin
    if (zbt_op != OP_IDLE) begin
      chk("op_gap", 64'(prev_op), 64'(OP_IDLE));
      if (exp_op.size() == 0) chk("op_unexpected", 64'(zbt_op), 64'(OP_IDLE));
      else begin
        mon_e = exp_op.pop_front();
        chk("op_kind", 64'(zbt_op), 64'(mon_e.op));
        chk("op_addr", 64'(zbt_addr), 64'(mon_e.addr));
        if (mon_e.op == OP_WRITE) begin
          chk("op_din", 64'(zbt_din), 64'(mon_e.din));
          chk("op_bwe", 64'(zbt_bwe), 64'(BWE_ALL));
        end
      end
    end
    prev_op = zbt_op;
  end
  always @(negedge clk_27mhz) begin
    if (rd_valid) begin
      n_rdv++;
      if (exp_rd.size() == 0) chk("rd_unexpected", 64'(rd_valid), 64'(0));
      else chk("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
    end
  end
  task automatic step(output bit gw, output bit gr);
    @(negedge clk_27mhz);
    gw = wr_ready;
    gr = rd_ack;
    if (gw) exp_write(wr_data);
    if (gr) exp_read();
    @(posedge clk_27mhz);
    #1;
  endtask
  task automatic do_write(input logic [DW-1:0] d);
    bit gw = 0, gr;
    int n = 0;
    wr_valid = 1'b1;
    wr_data = d;
    while (!gw && n < 40) begin step(gw, gr); n++; end
    wr_valid = 1'b0;
    chk("wr_handshake", 64'(gw), 64'(1));
  endtask
  task automatic do_read();
    bit gw, gr = 0;
    int n = 0;
    rd_req = 1'b1;
    while (!gr && n < 40) begin step(gw, gr); n++; end
    rd_req = 1'b0;
    chk("rd_handshake", 64'(gr), 64'(1));
  endtask
  task automatic drain();
    bit gw, gr;
    int n = 0;
    while ((exp_rd.size() > 0 || exp_op.size() > 0) && n < 100) begin step(gw, gr); n++; end
    chk("drain_rd", 64'(exp_rd.size()), 64'(0));
    chk("drain_op", 64'(exp_op.size()), 64'(0));
  endtask
  task automatic chk_state(input int c, input bit f, input bit e);
    chk("count", 64'(count), 64'(c));
    chk("full", 64'(full), 64'(f));
    chk("empty", 64'(empty), 64'(e));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bit gw, gr, got, froze;
    int acc, ng, base_rdv, n;
    logic [3:0] seq;
    reset = 1'b1; wr_valid = 1'b0; rd_req = 1'b0; wr_data = '0; zbt_ready = 1'b1;
    repeat (2) @(posedge clk_27mhz);
    @(negedge clk_27mhz);
    chk("rst_op", 64'(zbt_op), 64'(OP_IDLE));
    chk("rst_addr", 64'(zbt_addr), 64'(BASE));
    chk("rst_din", 64'(zbt_din), 64'(0));
    chk("rst_bwe", 64'(zbt_bwe), 64'(0));
    chk("rst_wr_ready", 64'(wr_ready), 64'(0));
    chk("rst_rd_ack", 64'(rd_ack), 64'(0));
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    chk_state(0, 0, 1);
    @(posedge clk_27mhz); #1;
    reset = 1'b0;
    do_write(36'hDEADACEDA);
    chk_state(1, 0, 0);
    do_write(36'hACAFEBABE);
    do_write(36'hABABECAFE);
    do_read();
    do_read();
    drain();
    chk_state(1, 0, 0);
    for (int i = 0; i < 7; i++) do_write(36'h111110000 + DW'(i));
    chk_state(8, 1, 0);
`ifdef ZBT_RB_OVERWRITE_EN
    do_write(36'h00F0F0F0F);
    chk_state(8, 1, 0);
`else
    wr_valid = 1'b1;
    wr_data = 36'h00F0F0F0F;
    acc = 0;
    repeat (10) begin step(gw, gr); acc += int'(gw); end
    wr_valid = 1'b0;
    chk("full_blocks_write", 64'(acc), 64'(0));
    chk_state(8, 1, 0);
`endif
    do_read();
    do_write(36'h222222222);
    drain();
    chk_state(8, 1, 0);
    repeat (6) do_read();
    drain();
    chk_state(2, 0, 0);
    wr_valid = 1'b1; rd_req = 1'b1; wr_data = 36'h444440000;
    seq = '0; ng = 0; froze = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      step(gw, gr);
      if (gw) begin seq = {seq[2:0], 1'b1}; ng++; wr_data = wr_data + 1'b1; end
      if (gr) begin seq = {seq[2:0], 1'b0}; ng++; end
      if (ng == 2 && !froze) begin
        froze = 1;
        zbt_ready = 1'b0;
        acc = 0;
        repeat (6) begin step(gw, gr); acc += int'(gw) + int'(gr); end
        zbt_ready = 1'b1;
        chk("ready_low_freezes", 64'(acc), 64'(0));
      end
    end
    wr_valid = 1'b0; rd_req = 1'b0;
    chk("rr_order_wrwr", 64'(seq), 64'(4'b1010));
    drain();
    chk_state(2, 0, 0);
    for (int i = 0; i < 4; i++) do_write(36'h333330000 + DW'(i));
    chk_state(6, 0, 0);
    nd_credit = 0;
    rd_req = 1'b1;
    acc = 0;
    repeat (20) begin step(gw, gr); acc += int'(gr); end
    chk("outstanding_cap", 64'(acc), 64'(4));
    chk("count_after_cap", 64'(count), 64'(2));
    base_rdv = n_rdv;
    nd_credit = 1;
    got = 0; n = 0;
    while (!got && n < 20) begin step(gw, got); n++; end
    rd_req = 1'b0;
    chk("ack_after_nd", 64'(got), 64'(1));
    repeat (4) step(gw, gr);
    chk("one_return", 64'(n_rdv - base_rdv), 64'(1));
    chk("count_before_reset", 64'(count), 64'(1));
    reset = 1'b1;
    @(posedge clk_27mhz); #1;
    reset = 1'b0;
    exp_rd.delete(); ring.delete(); tl = 0; hd = 0;
    @(negedge clk_27mhz);
    chk_state(0, 0, 1);
    chk("rst_mid_rd_valid", 64'(rd_valid), 64'(0));
    @(posedge clk_27mhz); #1;
    base_rdv = n_rdv;
    nd_credit = 100;
    repeat (8) step(gw, gr);
    chk("late_nd_ignored", 64'(n_rdv - base_rdv), 64'(0));
    rd_req = 1'b1;
    acc = 0;
    repeat (8) begin step(gw, gr); acc += int'(gr); end
    chk("empty_blocks_read", 64'(acc), 64'(0));
    wr_valid = 1'b1; wr_data = 36'h0BEEFF00D;
    got = 0; n = 0;
    while (!got && n < 30) begin
      step(gw, gr);
      if (gw) wr_valid = 1'b0;
      got = gr;
      n++;
    end
    rd_req = 1'b0; wr_valid = 1'b0;
    chk("held_read_served", 64'(got), 64'(1));
    drain();
    chk_state(0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/zbt_ring_buffer.md
Name: zbt_ring_buffer

Overview:
- Upstream command stage for ZBT_Interface: turns a streaming write port (audio/packet samples in) and a read-request port (samples out) into single-cycle IDLE/READ/WRITE ops on the ZBT_Interface command bus.
- Manages one circular region of ZBT SRAM with head/tail pointers and occupancy.
- Arbitrates read vs write fairly and returns read data, in order, on the ZBT_Interface nd strobe.

Parameters:
- ADDR_W, 19, ZBT word address width.
- DATA_W, 36, ZBT word width.
- BASE_ADDR, 19'h00000, first word of the ring region.
- DEPTH_LOG2, 16, ring holds 2^DEPTH_LOG2 words; BASE_ADDR + 2^DEPTH_LOG2 - 1 must not exceed 2^ADDR_W - 1.
- MAX_OUTSTANDING, 4, maximum issued reads not yet returned by nd.

Ports:
- clk_27mhz  in  1  system clock
- reset  in  1  synchronous, active-high
- wr_valid  in  1  write sample offered
- wr_data  in  DATA_W  write sample
- wr_ready  out  1  write accepted this cycle when wr_valid && wr_ready
- rd_req  in  1  request the oldest word
- rd_ack  out  1  read request accepted this cycle
- rd_data  out  DATA_W  returned word
- rd_valid  out  1  one-cycle strobe; rd_data valid
- count  out  DEPTH_LOG2+1  words stored (writes issued minus reads issued)
- full  out  1  count == 2^DEPTH_LOG2
- empty  out  1  count == 0
- zbt_op  out  2  to ZBT_Interface op: 00 IDLE, 01 READ, 10 WRITE
- zbt_addr  out  ADDR_W  to ZBT_Interface addr
- zbt_din  out  DATA_W  to ZBT_Interface din
- zbt_bwe  out  4  to ZBT_Interface bwe; active-high byte enables
- zbt_ready  in  1  from ZBT_Interface ready
- zbt_dout  in  DATA_W  from ZBT_Interface dout
- zbt_nd  in  1  from ZBT_Interface nd

Behaviour:
- Reset values:
  - zbt_op=IDLE, zbt_addr=BASE_ADDR, zbt_din=0, zbt_bwe=0.
  - wr_ready=0, rd_ack=0, rd_valid=0, rd_data=0.
  - count=0, empty=1, full=0.
  - Head, tail, outstanding count and priority flag cleared; priority flag means write-first.
- FSM states:
  - S_IDLE: select an op when zbt_ready=1 -> S_ISSUE. Stay in S_IDLE while zbt_ready=0.
  - S_ISSUE: drive the op for exactly one cycle -> S_GAP.
  - S_GAP: drive IDLE for one cycle -> S_IDLE.
  - Maximum throughput is therefore one op per 3 cycles. Every cycle outside S_ISSUE drives zbt_op=IDLE.
- Write eligible: wr_valid && !full.
  - wr_ready is a one-cycle pulse in the S_IDLE cycle that selects the write.
  - wr_data is registered into zbt_din that cycle; zbt_addr=BASE_ADDR+tail; zbt_bwe=4'hF.
- Read eligible: rd_req && !empty && outstanding<MAX_OUTSTANDING.
  - rd_ack pulses in the selecting cycle; zbt_addr=BASE_ADDR+head.
- Arbitration:
  - Only one eligible -> that one.
  - Both eligible -> side given by the priority flag; the flag toggles after each contested grant (round-robin).
- Pointers:
  - tail increments on write select, head on read select.
  - Both wrap modulo 2^DEPTH_LOG2; the address never leaves the region.
- count/full/empty:
  - Update in the select cycle, so a second request sees the new state.
  - Read and write never happen in the same cycle, so count changes by ±1 at most.
- Returns:
  - Each zbt_nd with outstanding>0: rd_data<=zbt_dout, rd_valid=1 next cycle, outstanding decrements.
  - zbt_nd with outstanding==0 is ignored.
  - A select and an nd in the same cycle net to no change in outstanding.
- Boundaries:
  - Full: wr_ready stays 0.
  - Empty: rd_ack stays 0, rd_req is held, not dropped.
  - Reset mid-operation: everything returns to reset values next cycle; in-flight reads are abandoned.

Optional Feature:
- Macro ZBT_RB_OVERWRITE_EN.
- Defined: when full, a write is still eligible. On that select, head also increments (oldest word discarded) and count stays at max.
- Not defined: full blocks writes as described above.

Decomposition:
- Package zbt_pkg holds:
  - OP_IDLE/OP_READ/OP_WRITE = 2'b00/01/10
  - FSM state encoding
  - BWE_ALL = 4'hF
- Natural sub-module: zbt_rr_arbiter, the 2-request round-robin grant with priority flag.

Test Plan:
- Reset, then wr_valid with 36'hDEADACEDA -> single WRITE op, addr 0, bwe F, then IDLE; count=1, empty=0.
- Write 36'hACAFEBABE, 36'hABABECAFE, then rd_req x2 -> READs to addr 0 and 1. Model returns data with nd; rd_data arrives in order: DEADACEDA, ACAFEBABE.
- DEPTH_LOG2=2: 4 writes -> full=1, wr_ready held 0. One read -> next write lands at BASE_ADDR+0 (wrap).
- wr_valid and rd_req held together with count=2 -> ops alternate W,R,W,R, each followed by one IDLE; zbt_ready=0 freezes issue.
- MAX_OUTSTANDING=4 with nd withheld -> 4th rd_ack, no 5th until nd. Then reset mid-burst -> count=0, late nd gives no rd_valid.
- With ZBT_RB_OVERWRITE_EN and DEPTH_LOG2=2: 5 writes -> count=4; first read returns the 2nd word.
